// File: rtl/uart_wb_arb.sv
// rtl/uart_wb_arb.sv - two-master round-robin Wishbone arbiter with ack timeout for the UART register port
// Grant is registered; slave-side controls are muxed from the owner only while in OWN.
module uart_wb_arb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            gnt_o,
  output logic [15:0]           to_cnt_o
);

  typedef enum logic [1:0] {IDLE, OWN, ERR, HOLD} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  gnt_nxt;
  logic        last, last_nxt;
  logic [15:0] timer, timer_nxt;
  logic [15:0] to_cnt_nxt;

  logic own_m1, own_cyc, own_stb;

  // last == 1 means m1 owned most recently, so m0 wins the first tie after reset
  assign own_m1  = gnt_o[1];
  assign own_cyc = own_m1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own_m1 ? m1_stb_i : m0_stb_i;

  assign m0_dat_o = gnt_o[0] ? s_dat_i : '0;
  assign m1_dat_o = gnt_o[1] ? s_dat_i : '0;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      gnt_o    <= 2'b00;
      last     <= 1'b1;
      timer    <= 16'd0;
      to_cnt_o <= 16'd0;
    end else begin
      state    <= state_nxt;
      gnt_o    <= gnt_nxt;
      last     <= last_nxt;
      timer    <= timer_nxt;
      to_cnt_o <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt_o;
    last_nxt   = last;
    timer_nxt  = timer;
    to_cnt_nxt = to_cnt_o;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = 4'b0000;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_err_o   = 1'b0;

    case (state)
      IDLE: begin
        timer_nxt = 16'd0;
        if (m0_cyc_i && m1_cyc_i) begin
          gnt_nxt   = last ? 2'b01 : 2'b10;
          state_nxt = OWN;
        end else if (m0_cyc_i) begin
          gnt_nxt   = 2'b01;
          state_nxt = OWN;
        end else if (m1_cyc_i) begin
          gnt_nxt   = 2'b10;
          state_nxt = OWN;
        end
      end

      OWN: begin
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        s_we_o   = own_m1 ? m1_we_i  : m0_we_i;
        s_sel_o  = own_m1 ? m1_sel_i : m0_sel_i;
        s_adr_o  = own_m1 ? m1_adr_i : m0_adr_i;
        s_dat_o  = own_m1 ? m1_dat_i : m0_dat_i;
        m0_ack_o = s_ack_i & gnt_o[0];
        m1_ack_o = s_ack_i & gnt_o[1];
        if (!own_cyc) begin
          last_nxt  = own_m1;
          gnt_nxt   = 2'b00;
          state_nxt = IDLE;
        end else if (!own_stb || s_ack_i) begin
          // an ack on the expiry cycle wins over the timeout
          timer_nxt = 16'd0;
        end else if (timer == TO_LAST) begin
          timer_nxt = 16'd0;
          state_nxt = ERR;
          if (to_cnt_o != 16'hFFFF) to_cnt_nxt = to_cnt_o + 16'd1;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end

      ERR: begin
        m0_err_o  = gnt_o[0];
        m1_err_o  = gnt_o[1];
        state_nxt = HOLD;
      end

      HOLD: begin
        if (!own_cyc) begin
          last_nxt  = own_m1;
          gnt_nxt   = 2'b00;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_wb_arb.sv
// tb/tb_uart_wb_arb.sv - directed bench for uart_wb_arb with TIMEOUT=8
module tb_uart_wb_arb;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [4:0]  m0_adr_i;
  logic [31:0] m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [4:0]  m1_adr_i;
  logic [31:0] m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [4:0]  s_adr_o;
  logic [31:0] s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;
  logic [15:0] to_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_wb_arb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .to_cnt_o(to_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [4:0]  lk_adr [3];
  logic [31:0] lk_dat [3];

  initial begin
    lk_adr[0] = 5'h3; lk_dat[0] = 32'h83;
    lk_adr[1] = 5'h0; lk_dat[1] = 32'h1B;
    lk_adr[2] = 5'h1; lk_dat[2] = 32'h00;

    wb_rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = 0; m1_dat_i = 0;
    s_dat_i = 0; s_ack_i = 0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_s_stb", 32'(s_stb_o), 32'h0);
    check("rst_to_cnt", 32'(to_cnt_o), 32'h0);
    check("rst_m0_ack", 32'(m0_ack_o), 32'h0);
    check("rst_m0_dat", m0_dat_o, 32'h0);
    wb_rst_i = 1'b0;

    // single master read of LCR
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 5'h3;
    #1;
    check("single_latency_gnt", 32'(gnt_o), 32'h0);
    check("single_idle_s_cyc", 32'(s_cyc_o), 32'h0);
    tick();
    check("single_gnt", 32'(gnt_o), 32'h1);
    check("single_s_adr", 32'(s_adr_o), 32'h3);
    check("single_s_stb", 32'(s_stb_o), 32'h1);
    s_ack_i = 1; s_dat_i = 32'h3;
    #1;
    check("single_m0_ack", 32'(m0_ack_o), 32'h1);
    check("single_m0_dat", m0_dat_o, 32'h3);
    check("single_m1_ack", 32'(m1_ack_o), 32'h0);
    check("single_m1_dat", m1_dat_o, 32'h0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    check("single_ack_drop", 32'(m0_ack_o), 32'h0);
    tick();
    check("single_release", 32'(gnt_o), 32'h0);

    // contention alternation from a fresh reset
    wb_rst_i = 1;
    tick();
    wb_rst_i = 0;
    m0_cyc_i = 1; m1_cyc_i = 1;
    for (int r = 0; r < 4; r++) begin
      tick();
      check($sformatf("rr_gnt%0d", r), 32'(gnt_o), (r % 2 == 0) ? 32'h1 : 32'h2);
      if (r % 2 == 0) m0_cyc_i = 0; else m1_cyc_i = 0;
      tick();
      check($sformatf("rr_dead%0d", r), 32'(gnt_o), 32'h0);
      m0_cyc_i = 1; m1_cyc_i = 1;
    end
    m0_cyc_i = 0; m1_cyc_i = 0;
    tick();

    // m1 locked three-write cycle with m0 waiting
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = lk_adr[0]; m1_dat_i = lk_dat[0];
    tick();
    check("lock_gnt_m1", 32'(gnt_o), 32'h2);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 5'h5;
    for (int b = 0; b < 3; b++) begin
      m1_adr_i = lk_adr[b]; m1_dat_i = lk_dat[b]; s_ack_i = 1;
      #1;
      check($sformatf("lock_adr%0d", b), 32'(s_adr_o), 32'(lk_adr[b]));
      check($sformatf("lock_dat%0d", b), s_dat_o, lk_dat[b]);
      check($sformatf("lock_we%0d", b), 32'(s_we_o), 32'h1);
      check($sformatf("lock_m1_ack%0d", b), 32'(m1_ack_o), 32'h1);
      check($sformatf("lock_m0_ack%0d", b), 32'(m0_ack_o), 32'h0);
      tick();
      check($sformatf("lock_hold%0d", b), 32'(gnt_o), 32'h2);
    end
    s_ack_i = 0; m1_stb_i = 0;
    tick();
    check("lock_still_m1", 32'(gnt_o), 32'h2);
    m1_cyc_i = 0; m1_we_i = 0;
    tick();
    check("lock_release", 32'(gnt_o), 32'h0);
    tick();
    check("lock_m0_gnt", 32'(gnt_o), 32'h1);

    // timeout: slave never acks, m1 pending
    m1_cyc_i = 1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("to_stb%0d", k), 32'(s_stb_o), 32'h1);
      check($sformatf("to_noerr%0d", k), 32'(m0_err_o), 32'h0);
      tick();
    end
    s_ack_i = 1;
    #1;
    check("to_err", 32'(m0_err_o), 32'h1);
    check("to_err_ack", 32'(m0_ack_o), 32'h0);
    check("to_err_s_stb", 32'(s_stb_o), 32'h0);
    check("to_err_s_cyc", 32'(s_cyc_o), 32'h0);
    check("to_err_m1", 32'(m1_err_o), 32'h0);
    check("to_cnt1", 32'(to_cnt_o), 32'h1);
    s_ack_i = 0;
    tick();
    check("to_hold_err", 32'(m0_err_o), 32'h0);
    check("to_hold_stb", 32'(s_stb_o), 32'h0);
    check("to_hold_gnt", 32'(gnt_o), 32'h1);
    tick();
    check("to_hold2_err", 32'(m0_err_o), 32'h0);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    check("to_release", 32'(gnt_o), 32'h0);
    tick();
    check("to_m1_gnt", 32'(gnt_o), 32'h2);
    m1_cyc_i = 0;
    tick();

    // ack arriving on the expiry cycle
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    check("race_gnt", 32'(gnt_o), 32'h1);
    for (int k = 0; k < 7; k++) tick();
    s_ack_i = 1; s_dat_i = 32'h55;
    #1;
    check("race_ack", 32'(m0_ack_o), 32'h1);
    check("race_dat", m0_dat_o, 32'h55);
    tick();
    s_ack_i = 0;
    #1;
    check("race_noerr", 32'(m0_err_o), 32'h0);
    check("race_own", 32'(gnt_o), 32'h1);
    check("race_stb", 32'(s_stb_o), 32'h1);
    check("race_to_cnt", 32'(to_cnt_o), 32'h1);
    // owner drops cyc together with ack
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 1;
    #1;
    check("drop_ack", 32'(m0_ack_o), 32'h1);
    tick();
    check("drop_release", 32'(gnt_o), 32'h0);
    check("idle_ack_ignored", 32'(m0_ack_o), 32'h0);
    s_ack_i = 0;

    // reset in the middle of an access
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    check("mid_gnt", 32'(gnt_o), 32'h1);
    tick();
    tick();
    wb_rst_i = 1;
    tick();
    check("mid_rst_gnt", 32'(gnt_o), 32'h0);
    check("mid_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("mid_rst_to_cnt", 32'(to_cnt_o), 32'h0);
    check("mid_rst_err", 32'(m0_err_o), 32'h0);
    s_ack_i = 1;
    #1;
    check("mid_rst_ack", 32'(m0_ack_o), 32'h0);
    wb_rst_i = 0; s_ack_i = 0;
    tick();
    check("post_rst_gnt", 32'(gnt_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
